// File: rtl/dtcm_resp.sv
// dtcm_resp: single-port data TCM with a 2-entry response FIFO.
// Requests are accepted when dmem_req_ready is high. Every accepted request,
// writes included, returns exactly one response, in acceptance order.
// Optional macro DTCM_WAIT_EN adds WAIT_CYCLES extra wait states per access.
// The wait states come from a small IDLE/WAIT FSM, a holding register and a
// down-counter. Without the macro an access responds on the next cycle.
//
// state | meaning
// IDLE  | free to accept a request (FIFO permitting)
// WAIT  | access in flight; counter counts down to 1, then the result is pushed
module dtcm_resp #(
    parameter int DEPTH_WORDS = 4096,
    parameter int WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        dmem_req_valid,
    output logic        dmem_req_ready,
    input  logic [31:0] dmem_req_addr,
    input  logic        dmem_req_we,
    input  logic [31:0] dmem_req_wdata,
    input  logic [3:0]  dmem_req_wstrb,
    output logic        dmem_resp_valid,
    input  logic        dmem_resp_ready,
    output logic [31:0] dmem_resp_data,
    output logic        dmem_resp_err
);
    localparam int AW = $clog2(DEPTH_WORDS);

    logic [31:0]   mem [DEPTH_WORDS];
    logic [AW-1:0] idx;
    logic          in_range;
    logic          accept;
    logic          pop;
    logic          push;
    logic [31:0]   rd_word;
    logic [31:0]   push_data;
    logic          push_err;
    logic [1:0]    count;
    logic [31:0]   head_data;
    logic [31:0]   tail_data;
    logic          head_err;
    logic          tail_err;
    logic          ready_en;
    logic          unused_addr_lsbs;

    assign unused_addr_lsbs = ^dmem_req_addr[1:0];

    assign idx      = dmem_req_addr[AW+1:2];
    assign in_range = (dmem_req_addr[31:AW+2] == '0);
    assign accept   = dmem_req_valid && dmem_req_ready;
    assign pop      = (count != 2'd0) && dmem_resp_ready;
    // Writes and out-of-range accesses both return data 0.
    assign rd_word  = (in_range && !dmem_req_we) ? mem[idx] : 32'h0;

    // Byte-masked store at the acceptance edge. Storage is deliberately not
    // reset, so contents survive rstn.
    always_ff @(posedge clk) begin
        if (accept && dmem_req_we && in_range) begin
            for (int b = 0; b < 4; b++) begin
                if (dmem_req_wstrb[b]) begin
                    mem[idx][8*b +: 8] <= dmem_req_wdata[8*b +: 8];
                end
            end
        end
    end

    // Keeps ready low through reset and sets it on the first edge after release.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            ready_en <= 1'b0;
        end else begin
            ready_en <= 1'b1;
        end
    end

`ifdef DTCM_WAIT_EN
    typedef enum logic {IDLE, WAIT} state_t;

    state_t      fsm;
    logic [3:0]  wait_cnt;
    logic [31:0] hold_data;
    logic        hold_err;

    assign dmem_req_ready = ready_en && !count[1] && (fsm == IDLE);
    assign push           = (fsm == WAIT) && (wait_cnt == 4'd1);
    assign push_data      = hold_data;
    assign push_err       = hold_err;

    // Wait-state sequencer: capture the access result, count down, then release
    // the result to the FIFO on the edge where the counter reads 1.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            fsm       <= IDLE;
            wait_cnt  <= 4'd0;
            hold_data <= 32'h0;
            hold_err  <= 1'b0;
        end else begin
            case (fsm)
                IDLE: begin
                    if (accept) begin
                        fsm       <= WAIT;
                        wait_cnt  <= 4'(WAIT_CYCLES);
                        hold_data <= rd_word;
                        hold_err  <= !in_range;
                    end
                end
                WAIT: begin
                    wait_cnt <= wait_cnt - 4'd1;
                    if (wait_cnt == 4'd1) begin
                        fsm <= IDLE;
                    end
                end
                default: fsm <= IDLE;
            endcase
        end
    end
`else
    logic [3:0] unused_wait_cycles;

    assign unused_wait_cycles = 4'(WAIT_CYCLES);
    assign dmem_req_ready     = ready_en && !count[1];
    assign push               = accept;
    assign push_data          = rd_word;
    assign push_err           = !in_range;
`endif

    // Two-entry response FIFO. The head register drives the outputs directly.
    // When the FIFO empties, the head drains to zeros.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            count     <= 2'd0;
            head_data <= 32'h0;
            head_err  <= 1'b0;
            tail_data <= 32'h0;
            tail_err  <= 1'b0;
        end else begin
            case ({push, pop})
                2'b10: begin
                    if (count == 2'd0) begin
                        head_data <= push_data;
                        head_err  <= push_err;
                    end else begin
                        tail_data <= push_data;
                        tail_err  <= push_err;
                    end
                    count <= count + 2'd1;
                end
                2'b01: begin
                    head_data <= tail_data;
                    head_err  <= tail_err;
                    tail_data <= 32'h0;
                    tail_err  <= 1'b0;
                    count     <= count - 2'd1;
                end
                2'b11: begin
                    if (count == 2'd1) begin
                        head_data <= push_data;
                        head_err  <= push_err;
                    end else begin
                        head_data <= tail_data;
                        head_err  <= tail_err;
                        tail_data <= push_data;
                        tail_err  <= push_err;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign dmem_resp_valid = (count != 2'd0);
    assign dmem_resp_data  = head_data;
    assign dmem_resp_err   = head_err;

endmodule

// File: tb/tb_dtcm_resp.sv
// Testbench for dtcm_resp. A negedge monitor logs every response handshake.
// Each test task compares the logged responses against a reference memory
// model's expectations, queued at request acceptance.
module tb_dtcm_resp;
    localparam int DEPTH = 4096;
    localparam int WAITC = 2;
    localparam int AW    = 12;
`ifdef DTCM_WAIT_EN
    localparam int LAT = 1 + WAITC;
`else
    localparam int LAT = 1;
`endif

    typedef struct packed {
        logic [31:0] data;
        logic        err;
    } resp_t;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        dmem_req_valid = 1'b0;
    logic        dmem_req_ready;
    logic [31:0] dmem_req_addr = 32'h0;
    logic        dmem_req_we = 1'b0;
    logic [31:0] dmem_req_wdata = 32'h0;
    logic [3:0]  dmem_req_wstrb = 4'h0;
    logic        dmem_resp_valid;
    logic        dmem_resp_ready = 1'b0;
    logic [31:0] dmem_resp_data;
    logic        dmem_resp_err;

    int          n_pass = 0;
    int          n_total = 0;
    int          timeouts = 0;
    int          cyc = 0;
    resp_t       exp_q[$];
    resp_t       obs_q[$];
    logic [31:0] mdl [DEPTH];

    always #5 clk = ~clk;

    dtcm_resp #(.DEPTH_WORDS(DEPTH), .WAIT_CYCLES(WAITC)) dut (
        .clk(clk),
        .rstn(rstn),
        .dmem_req_valid(dmem_req_valid),
        .dmem_req_ready(dmem_req_ready),
        .dmem_req_addr(dmem_req_addr),
        .dmem_req_we(dmem_req_we),
        .dmem_req_wdata(dmem_req_wdata),
        .dmem_req_wstrb(dmem_req_wstrb),
        .dmem_resp_valid(dmem_resp_valid),
        .dmem_resp_ready(dmem_resp_ready),
        .dmem_resp_data(dmem_resp_data),
        .dmem_resp_err(dmem_resp_err)
    );

    always @(posedge clk) cyc = cyc + 1;

    // Response monitor: a handshake seen at the negedge completes at the next edge.
    always @(negedge clk) begin
        if (rstn && dmem_resp_valid && dmem_resp_ready)
            obs_q.push_back('{data: dmem_resp_data, err: dmem_resp_err});
    end

    function automatic void model_accept(logic [31:0] a, logic we, logic [31:0] wd, logic [3:0] ws);
        resp_t         r;
        logic [AW-1:0] ix;
        r.data = 32'h0;
        r.err  = !(a[31:2] < DEPTH);
        ix     = a[AW+1:2];
        if (!r.err) begin
            if (we) begin
                for (int b = 0; b < 4; b++)
                    if (ws[b]) mdl[ix][8*b +: 8] = wd[8*b +: 8];
            end else begin
                r.data = mdl[ix];
            end
        end
        exp_q.push_back(r);
    endfunction

    // Called and returns at posedge+1; holds valid until accepted or the bound expires.
    task automatic issue(input logic [31:0] a, input logic we, input logic [31:0] wd, input logic [3:0] ws);
        bit ok = 0;
        dmem_req_valid = 1'b1;
        dmem_req_addr  = a;
        dmem_req_we    = we;
        dmem_req_wdata = wd;
        dmem_req_wstrb = ws;
        for (int i = 0; i < 64 && !ok; i++) begin
            @(negedge clk);
            if (dmem_req_ready) begin
                model_accept(a, we, wd, ws);
                ok = 1;
            end
            @(posedge clk); #1;
        end
        dmem_req_valid = 1'b0;
        if (!ok) timeouts++;
    endtask

    task automatic drain(output bit ok);
        ok = 0;
        for (int i = 0; i < 200; i++) begin
            if (obs_q.size() >= exp_q.size()) begin
                ok = 1;
                break;
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_reset();
        rstn = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_total++; if (dmem_req_ready !== 1'b0) $display("FAIL rst_ready: got %b want 0", dmem_req_ready); else n_pass++;
        n_total++; if (dmem_resp_valid !== 1'b0) $display("FAIL rst_valid: got %b want 0", dmem_resp_valid); else n_pass++;
        n_total++; if (dmem_resp_data !== 32'h0) $display("FAIL rst_data: got %h want 0", dmem_resp_data); else n_pass++;
        n_total++; if (dmem_resp_err !== 1'b0) $display("FAIL rst_err: got %b want 0", dmem_resp_err); else n_pass++;
        rstn = 1'b1;
        @(posedge clk); #1;
        n_total++; if (dmem_req_ready !== 1'b1) $display("FAIL post_rst_ready: got %b want 1", dmem_req_ready); else n_pass++;
        n_total++; if (dmem_resp_valid !== 1'b0) $display("FAIL post_rst_valid: got %b want 0", dmem_resp_valid); else n_pass++;
    endtask

    task automatic test_read_word0();
        bit ok;
        resp_t e, o;
        dmem_resp_ready = 1'b1;
        issue(32'h0, 1'b1, 32'hDEADBEEF, 4'hF);
        issue(32'h0, 1'b0, 32'h0, 4'h0);
        for (int k = 1; k <= LAT; k++) begin
            @(negedge clk);
            n_total++;
            if (dmem_resp_valid !== (k == LAT)) $display("FAIL rd_lat_valid: cycle +%0d got %b want %b", k, dmem_resp_valid, (k == LAT));
            else n_pass++;
            if (k == LAT) begin
                n_total++; if (dmem_resp_data !== 32'hDEADBEEF) $display("FAIL rd0_data: got %h want deadbeef", dmem_resp_data); else n_pass++;
                n_total++; if (dmem_resp_err !== 1'b0) $display("FAIL rd0_err: got %b want 0", dmem_resp_err); else n_pass++;
            end else begin
                n_total++; if (dmem_req_ready !== 1'b0) $display("FAIL rd_wait_ready: cycle +%0d got %b want 0", k, dmem_req_ready); else n_pass++;
            end
        end
        @(posedge clk); #1;
        drain(ok);
        n_total++; if (!ok) $display("FAIL rd0_drain: got %0d responses want %0d", obs_q.size(), exp_q.size()); else n_pass++;
        while (exp_q.size() != 0 && obs_q.size() != 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front();
            n_total++;
            if (o !== e) $display("FAIL rd0_resp: got data=%h err=%b want data=%h err=%b", o.data, o.err, e.data, e.err);
            else n_pass++;
        end
    endtask

    task automatic test_byte_strobe();
        bit ok;
        resp_t e, o;
        logic [31:0] got;
        issue(32'h8, 1'b1, 32'hAABBCCDD, 4'hF);
        issue(32'h8, 1'b1, 32'h11223344, 4'b0101);
        issue(32'h8, 1'b0, 32'h0, 4'h0);
        drain(ok);
        n_total++; if (!ok) $display("FAIL strb_drain: got %0d responses want %0d", obs_q.size(), exp_q.size()); else n_pass++;
        got = (obs_q.size() > 2) ? obs_q[2].data : 32'hx;
        n_total++; if (got !== 32'hAA22CC44) $display("FAIL strb_merge: got %h want aa22cc44", got); else n_pass++;
        got = (obs_q.size() > 1) ? obs_q[1].data : 32'hx;
        n_total++; if (got !== 32'h0) $display("FAIL strb_wr_resp: got %h want 0", got); else n_pass++;
        while (exp_q.size() != 0 && obs_q.size() != 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front();
            n_total++;
            if (o !== e) $display("FAIL strb_resp: got data=%h err=%b want data=%h err=%b", o.data, o.err, e.data, e.err);
            else n_pass++;
        end
    endtask

    task automatic test_backpressure();
        bit ok;
        resp_t e, o;
        issue(32'h4, 1'b1, 32'h55667788, 4'hF);
        drain(ok);
        while (exp_q.size() != 0 && obs_q.size() != 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front();
            n_total++;
            if (o !== e) $display("FAIL bp_pre_resp: got data=%h err=%b want data=%h err=%b", o.data, o.err, e.data, e.err);
            else n_pass++;
        end
        dmem_resp_ready = 1'b0;
        issue(32'h0, 1'b0, 32'h0, 4'h0);
        issue(32'h4, 1'b0, 32'h0, 4'h0);
        dmem_req_valid = 1'b1;
        dmem_req_addr  = 32'h8;
        dmem_req_we    = 1'b0;
        for (int k = 0; k < LAT + 2; k++) begin
            @(negedge clk);
            n_total++; if (dmem_req_ready !== 1'b0) $display("FAIL bp_ready_low: cycle %0d got %b want 0", k, dmem_req_ready); else n_pass++;
            if (k == LAT + 1) begin
                n_total++; if (dmem_resp_valid !== 1'b1) $display("FAIL bp_valid: got %b want 1", dmem_resp_valid); else n_pass++;
            end
            if (dmem_resp_valid) begin
                n_total++;
                if (exp_q.size() == 0 || dmem_resp_data !== exp_q[0].data)
                    $display("FAIL bp_head_stable: cycle %0d got %h want %h", k, dmem_resp_data, (exp_q.size() != 0) ? exp_q[0].data : 32'hx);
                else n_pass++;
            end
            @(posedge clk); #1;
        end
        dmem_resp_ready = 1'b1;
        @(negedge clk);
        n_total++; if (dmem_req_ready !== 1'b0) $display("FAIL bp_ready_at_pop: got %b want 0", dmem_req_ready); else n_pass++;
        @(posedge clk); #1;
        @(negedge clk);
        n_total++;
        if (dmem_req_ready !== 1'b1) $display("FAIL bp_ready_after_pop: got %b want 1", dmem_req_ready);
        else begin
            n_pass++;
            model_accept(32'h8, 1'b0, 32'h0, 4'h0);
        end
        @(posedge clk); #1;
        dmem_req_valid = 1'b0;
        drain(ok);
        n_total++; if (!ok) $display("FAIL bp_drain: got %0d responses want %0d", obs_q.size(), exp_q.size()); else n_pass++;
        while (exp_q.size() != 0 && obs_q.size() != 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front();
            n_total++;
            if (o !== e) $display("FAIL bp_order: got data=%h err=%b want data=%h err=%b", o.data, o.err, e.data, e.err);
            else n_pass++;
        end
    endtask

    task automatic test_out_of_range();
        bit ok;
        resp_t e, o;
        logic got_err;
        logic [31:0] got;
        issue(DEPTH * 4, 1'b0, 32'h0, 4'h0);
        issue(DEPTH * 4, 1'b1, 32'hFFFFFFFF, 4'hF);
        issue(32'h0, 1'b0, 32'h0, 4'h0);
        issue(32'hFFFFFFFC, 1'b0, 32'h0, 4'h0);
        drain(ok);
        n_total++; if (!ok) $display("FAIL oor_drain: got %0d responses want %0d", obs_q.size(), exp_q.size()); else n_pass++;
        got_err = (obs_q.size() > 1) ? obs_q[1].err : 1'bx;
        n_total++; if (got_err !== 1'b1) $display("FAIL oor_wr_err: got %b want 1", got_err); else n_pass++;
        got = (obs_q.size() > 2) ? obs_q[2].data : 32'hx;
        n_total++; if (got !== 32'hDEADBEEF) $display("FAIL oor_no_alias: got %h want deadbeef", got); else n_pass++;
        while (exp_q.size() != 0 && obs_q.size() != 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front();
            n_total++;
            if (o !== e) $display("FAIL oor_resp: got data=%h err=%b want data=%h err=%b", o.data, o.err, e.data, e.err);
            else n_pass++;
        end
    endtask

    task automatic test_throughput();
        bit ok;
        resp_t e, o;
        int k = 0;
        int last = 0;
        logic [31:0] a;
        logic we;
        logic [31:0] wd;
        dmem_resp_ready = 1'b1;
        a = 32'h40; we = 1'b1; wd = $urandom;
        dmem_req_valid = 1'b1; dmem_req_addr = a; dmem_req_we = we; dmem_req_wdata = wd; dmem_req_wstrb = 4'hF;
        for (int i = 0; i < 100 && k < 8; i++) begin
            @(negedge clk);
            if (dmem_req_ready) begin
                model_accept(a, we, wd, 4'hF);
                if (k > 0) begin
                    n_total++;
                    if (cyc - last !== LAT) $display("FAIL tput_gap: req %0d got %0d cycles want %0d", k, cyc - last, LAT);
                    else n_pass++;
                end
                last = cyc;
                k++;
                we = ~we;
                if (we) begin
                    a = 32'h40 + 32'(4 * k);
                    wd = $urandom;
                end
            end
            @(posedge clk); #1;
            dmem_req_addr = a; dmem_req_we = we; dmem_req_wdata = wd;
        end
        dmem_req_valid = 1'b0;
        n_total++; if (k !== 8) $display("FAIL tput_count: got %0d accepted want 8", k); else n_pass++;
        drain(ok);
        n_total++; if (!ok) $display("FAIL tput_drain: got %0d responses want %0d", obs_q.size(), exp_q.size()); else n_pass++;
        while (exp_q.size() != 0 && obs_q.size() != 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front();
            n_total++;
            if (o !== e) $display("FAIL tput_resp: got data=%h err=%b want data=%h err=%b", o.data, o.err, e.data, e.err);
            else n_pass++;
        end
    endtask

    task automatic test_reset_mid();
        bit ok;
        resp_t e, o;
        issue(32'hC, 1'b1, 32'hCAFEF00D, 4'hF);
        drain(ok);
        while (exp_q.size() != 0 && obs_q.size() != 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front();
            n_total++;
            if (o !== e) $display("FAIL rm_pre_resp: got data=%h err=%b want data=%h err=%b", o.data, o.err, e.data, e.err);
            else n_pass++;
        end
        dmem_resp_ready = 1'b0;
        issue(32'h0, 1'b0, 32'h0, 4'h0);
        issue(32'hC, 1'b0, 32'h0, 4'h0);
        repeat (LAT + 2) begin
            @(posedge clk); #1;
        end
        n_total++; if (dmem_resp_valid !== 1'b1) $display("FAIL rm_queued: got %b want 1", dmem_resp_valid); else n_pass++;
        rstn = 1'b0;
        #1;
        n_total++; if (dmem_resp_valid !== 1'b0) $display("FAIL rm_valid: got %b want 0", dmem_resp_valid); else n_pass++;
        n_total++; if (dmem_resp_data !== 32'h0) $display("FAIL rm_data: got %h want 0", dmem_resp_data); else n_pass++;
        n_total++; if (dmem_req_ready !== 1'b0) $display("FAIL rm_ready: got %b want 0", dmem_req_ready); else n_pass++;
        exp_q.delete();
        obs_q.delete();
        @(negedge clk);
        rstn = 1'b1;
        @(posedge clk); #1;
        n_total++; if (dmem_req_ready !== 1'b1) $display("FAIL rm_ready_after: got %b want 1", dmem_req_ready); else n_pass++;
        dmem_resp_ready = 1'b1;
        issue(32'hC, 1'b0, 32'h0, 4'h0);
        drain(ok);
        n_total++; if (!ok) $display("FAIL rm_drain: got %0d responses want %0d", obs_q.size(), exp_q.size()); else n_pass++;
        n_total++;
        if (obs_q.size() == 0 || obs_q[0].data !== 32'hCAFEF00D)
            $display("FAIL rm_persist: got %h want cafef00d", (obs_q.size() != 0) ? obs_q[0].data : 32'hx);
        else n_pass++;
        while (exp_q.size() != 0 && obs_q.size() != 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front();
            n_total++;
            if (o !== e) $display("FAIL rm_resp: got data=%h err=%b want data=%h err=%b", o.data, o.err, e.data, e.err);
            else n_pass++;
        end
    endtask

    initial begin
        for (int i = 0; i < DEPTH; i++) mdl[i] = 32'h0;
        test_reset();
        test_read_word0();
        test_byte_strobe();
        test_backpressure();
        test_out_of_range();
        test_throughput();
        test_reset_mid();
        n_total++; if (timeouts !== 0) $display("FAIL accept_timeout: got %0d timeouts want 0", timeouts); else n_pass++;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end
endmodule
